// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard unit.
// Holds the forward-select encodings, the stage index constants and the
// scoreboard entry type used by pipeline_hazard_unit and hazard_fwd_sel.
// The register-number field of an entry is sized for the widest register
// file supported (RN_MAX_W); narrower REG_AW values are zero-extended.
package pipe_pkg;

    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_EXE     = 2'd1;
    localparam logic [1:0] FWD_MEM_ALU = 2'd2;
    localparam logic [1:0] FWD_MEM_LD  = 2'd3;

    localparam int ST_EXE = 2;
    localparam int ST_MEM = 3;

    localparam int RN_MAX_W = 8;

    typedef struct packed {
        logic                valid;
        logic                wreg;
        logic                m2reg;
        logic [RN_MAX_W-1:0] rn;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, wreg: 1'b0, m2reg: 1'b0,
                                       rn: {RN_MAX_W{1'b0}}};

    // An entry produces register r when it is live, writes, targets r and r is not r0.
    function automatic logic is_producer(input sb_entry_t e, input logic [RN_MAX_W-1:0] r);
        return e.valid & e.wreg & (e.rn != {RN_MAX_W{1'b0}}) & (e.rn == r);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-source hazard check and forward select.
// Ports: src_valid (source really read by a real ID instruction), src
// (source register), exe/mem/wb (scoreboard entries); fwd (operand select),
// stall (this source cannot proceed this cycle).
// With FWD_EN the youngest matching producer wins; only a load still in EXE
// stalls. Without FWD_EN any matching producer, including WB, stalls.
module hazard_fwd_sel
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              src_valid,
    input  logic [REG_AW-1:0] src,
    input  sb_entry_t         exe,
    input  sb_entry_t         mem,
    input  sb_entry_t         wb,
    output logic [1:0]        fwd,
    output logic              stall
);

    logic [RN_MAX_W-1:0] src_ext_s;
    logic                hit_exe_s;
    logic                hit_mem_s;
    logic                hit_wb_s;
    logic                unused_s;

    assign src_ext_s = RN_MAX_W'(src);
    assign hit_exe_s = src_valid & is_producer(exe, src_ext_s);
    assign hit_mem_s = src_valid & is_producer(mem, src_ext_s);
    assign hit_wb_s  = src_valid & is_producer(wb, src_ext_s);
    assign unused_s  = wb.m2reg;

    // Select operand source and flag a stall for this source register.
    always_comb begin
        fwd   = FWD_RF;
        stall = 1'b0;
        if (FWD_EN) begin
            stall = hit_exe_s & exe.m2reg;
            if (hit_exe_s & ~exe.m2reg) begin
                fwd = FWD_EXE;
            end else if (hit_mem_s & mem.m2reg) begin
                fwd = FWD_MEM_LD;
            end else if (hit_mem_s) begin
                fwd = FWD_MEM_ALU;
            end else begin
                fwd = FWD_RF;
            end
        end else begin
            stall = hit_exe_s | hit_mem_s | hit_wb_s;
            fwd   = FWD_RF;
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and pipeline-control unit for the five-stage core.
// Tracks EXE/MEM/WB destination state and drives:
//   pc_we, ir_we        PC and IF/ID write enables
//   ir_flush            squash IF/ID on a redirect
//   idex_bubble         NOP into ID/EXE (stall or redirect)
//   exmem_bubble        NOP into EXE/MEM (redirect resolved in MEM)
//   pipe_hold           freeze everything while data memory is busy
//   fwd_a, fwd_b        ID operand forwarding selects
//   stall_cnt           saturating count of non-advancing cycles
// Priority: hold > redirect > data stall. REG_AW must not exceed RN_MAX_W.
module pipeline_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter bit FWD_EN       = 1'b1,
    parameter int BRANCH_STAGE = 3,
    parameter int CNT_W        = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic [REG_AW-1:0] id_rn,
    input  logic              br_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_we,
    output logic              ir_we,
    output logic              ir_flush,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic              pipe_hold,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic SQUASH_EXE = (BRANCH_STAGE == ST_MEM) ? 1'b1 : 1'b0;

    sb_entry_t exe_r;
    sb_entry_t mem_r;
    sb_entry_t wb_r;
    sb_entry_t exe_in_s;
    logic      stall_a_s;
    logic      stall_b_s;
    logic      data_stall_s;
    logic      redirect_s;
    logic      count_s;

    hazard_fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_sel_a (
        .src_valid (id_valid & id_use_rs),
        .src       (id_rs),
        .exe       (exe_r),
        .mem       (mem_r),
        .wb        (wb_r),
        .fwd       (fwd_a),
        .stall     (stall_a_s)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_sel_b (
        .src_valid (id_valid & id_use_rt),
        .src       (id_rt),
        .exe       (exe_r),
        .mem       (mem_r),
        .wb        (wb_r),
        .fwd       (fwd_b),
        .stall     (stall_b_s)
    );

    assign pipe_hold    = mem_req & ~mem_ready;
    assign redirect_s   = br_taken & ~pipe_hold;
    assign data_stall_s = stall_a_s | stall_b_s;
    // A redirect discards the stalled instruction, so it is not a lost cycle.
    assign count_s      = pipe_hold | (data_stall_s & ~redirect_s);

    // Pipeline control outputs, in priority order hold > redirect > stall.
    always_comb begin
        pc_we        = 1'b1;
        ir_we        = 1'b1;
        ir_flush     = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        if (pipe_hold) begin
            pc_we = 1'b0;
            ir_we = 1'b0;
        end else if (redirect_s) begin
            ir_flush     = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = SQUASH_EXE;
        end else if (data_stall_s) begin
            pc_we       = 1'b0;
            ir_we       = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            pc_we = 1'b1;
        end
    end

    // Entry that ID would hand to EXE; a bubble enters as invalid.
    always_comb begin
        exe_in_s       = SB_EMPTY;
        exe_in_s.valid = id_valid & ~idex_bubble;
        exe_in_s.wreg  = id_wreg;
        exe_in_s.m2reg = id_m2reg;
        exe_in_s.rn    = RN_MAX_W'(id_rn);
    end

    // Scoreboard shift and saturating stall counter.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            exe_r     <= SB_EMPTY;
            mem_r     <= SB_EMPTY;
            wb_r      <= SB_EMPTY;
            stall_cnt <= {CNT_W{1'b0}};
        end else begin
            if (!pipe_hold) begin
                wb_r  <= mem_r;
                mem_r <= exmem_bubble ? SB_EMPTY : exe_r;
                exe_r <= exe_in_s;
            end else begin
                wb_r  <= wb_r;
                mem_r <= mem_r;
                exe_r <= exe_r;
            end
            if (count_s && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
                stall_cnt <= stall_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit. Two instances share the stimulus:
// index 0 = forwarding, branch resolved in MEM, 16-bit counter;
// index 1 = full interlock, branch resolved in EXE, 4-bit counter.
// Each has a reference model holding the three in-flight instructions.
module tb_pipeline_hazard_unit;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg;
    logic [4:0] id_rs, id_rt, id_rn;
    logic       br_taken, mem_req, mem_ready;

    logic        f_pc_we, f_ir_we, f_ir_flush, f_idex, f_exmem, f_hold;
    logic [1:0]  f_fwd_a, f_fwd_b;
    logic [15:0] f_cnt;
    logic        n_pc_we, n_ir_we, n_ir_flush, n_idex, n_exmem, n_hold;
    logic [1:0]  n_fwd_a, n_fwd_b;
    logic [3:0]  n_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit v;
        bit w;
        bit ld;
        int rn;
    } ins_t;

    // model state: [dut][0=EXE,1=MEM,2=WB]
    ins_t mdl[2][3];
    int   mcnt[2];

    always #5 Clock = ~Clock;

    pipeline_hazard_unit #(.REG_AW(5), .FWD_EN(1'b1), .BRANCH_STAGE(3), .CNT_W(16)) dut_f (
        .Clock(Clock), .Resetn(Resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_rn(id_rn), .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(f_pc_we), .ir_we(f_ir_we), .ir_flush(f_ir_flush), .idex_bubble(f_idex),
        .exmem_bubble(f_exmem), .pipe_hold(f_hold), .fwd_a(f_fwd_a), .fwd_b(f_fwd_b),
        .stall_cnt(f_cnt)
    );

    pipeline_hazard_unit #(.REG_AW(5), .FWD_EN(1'b0), .BRANCH_STAGE(2), .CNT_W(4)) dut_n (
        .Clock(Clock), .Resetn(Resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_rn(id_rn), .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(n_pc_we), .ir_we(n_ir_we), .ir_flush(n_ir_flush), .idex_bubble(n_idex),
        .exmem_bubble(n_exmem), .pipe_hold(n_hold), .fwd_a(n_fwd_a), .fwd_b(n_fwd_b),
        .stall_cnt(n_cnt)
    );

    function automatic bit fwd_on(input int d);
        return (d == 0);
    endfunction

    function automatic int cnt_max(input int d);
        return (d == 0) ? 65535 : 15;
    endfunction

    // Stage of the youngest in-flight writer of src, or -1.
    function automatic int youngest(input int d, input int src, input bit use_src);
        if (!id_valid || !use_src || src == 0) return -1;
        for (int k = 0; k < 3; k++)
            if (mdl[d][k].v && mdl[d][k].w && mdl[d][k].rn == src) return k;
        return -1;
    endfunction

    function automatic int fsel(input int d, input int y);
        if (!fwd_on(d)) return 0;
        if (y == 0) return mdl[d][0].ld ? 0 : 1;
        if (y == 1) return mdl[d][1].ld ? 3 : 2;
        return 0;
    endfunction

    task automatic model_eval(input int d, output bit pc, output bit ir, output bit fl,
                              output bit ib, output bit eb, output bit ph, output bit dst,
                              output bit rd, output int fa, output int fb);
        int ya, yb;
        ph = mem_req && !mem_ready;
        rd = br_taken && !ph;
        ya = youngest(d, int'(id_rs), id_use_rs);
        yb = youngest(d, int'(id_rt), id_use_rt);
        if (fwd_on(d)) dst = (ya == 0 && mdl[d][0].ld) || (yb == 0 && mdl[d][0].ld);
        else           dst = (ya >= 0) || (yb >= 0);
        fa = fsel(d, ya);
        fb = fsel(d, yb);
        pc = ph ? 1'b0 : (rd ? 1'b1 : !dst);
        ir = ph ? 1'b0 : (rd ? 1'b1 : !dst);
        fl = rd;
        ib = !ph && (rd || dst);
        eb = rd && (d == 0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int d, input string nm, input logic pc, input logic ir,
                             input logic fl, input logic ib, input logic eb, input logic ph,
                             input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] cnt);
        bit e_pc, e_ir, e_fl, e_ib, e_eb, e_ph, e_dst, e_rd;
        int e_fa, e_fb;
        model_eval(d, e_pc, e_ir, e_fl, e_ib, e_eb, e_ph, e_dst, e_rd, e_fa, e_fb);
        chk({nm, "_pc_we"}, 32'(pc), 32'(e_pc));
        if (!e_rd) chk({nm, "_ir_we"}, 32'(ir), 32'(e_ir));
        chk({nm, "_ir_flush"}, 32'(fl), 32'(e_fl));
        chk({nm, "_idex_bubble"}, 32'(ib), 32'(e_ib));
        chk({nm, "_exmem_bubble"}, 32'(eb), 32'(e_eb));
        chk({nm, "_pipe_hold"}, 32'(ph), 32'(e_ph));
        if (!e_dst || !fwd_on(d)) begin
            chk({nm, "_fwd_a"}, 32'(fa), 32'(e_fa));
            chk({nm, "_fwd_b"}, 32'(fb), 32'(e_fb));
        end
        chk({nm, "_stall_cnt"}, cnt, 32'(mcnt[d]));
    endtask

    task automatic check_all();
        if (Resetn) begin
            check_dut(0, "f", f_pc_we, f_ir_we, f_ir_flush, f_idex, f_exmem, f_hold,
                      f_fwd_a, f_fwd_b, 32'(f_cnt));
            check_dut(1, "n", n_pc_we, n_ir_we, n_ir_flush, n_idex, n_exmem, n_hold,
                      n_fwd_a, n_fwd_b, 32'(n_cnt));
        end
    endtask

    // Apply ID/control inputs, let them settle, compare against the models.
    task automatic drive(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                         input bit w, input bit ld, input int rn,
                         input bit br, input bit req, input bit rdy);
        id_valid = v; id_rs = 5'(rs); id_use_rs = urs; id_rt = 5'(rt); id_use_rt = urt;
        id_wreg = w; id_m2reg = ld; id_rn = 5'(rn);
        br_taken = br; mem_req = req; mem_ready = rdy;
        #1;
        check_all();
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    // Advance one clock and move both models forward by the same rules.
    task automatic tick();
        bit pc, ir, fl, ib, eb, ph, dst, rd;
        int fa, fb;
        bit ph_v[2], ib_v[2], eb_v[2], cnt_v[2];
        for (int d = 0; d < 2; d++) begin
            model_eval(d, pc, ir, fl, ib, eb, ph, dst, rd, fa, fb);
            ph_v[d] = ph; ib_v[d] = ib; eb_v[d] = eb;
            cnt_v[d] = ph || (dst && !rd);
        end
        @(posedge Clock);
        for (int d = 0; d < 2; d++) begin
            if (!Resetn) begin
                for (int k = 0; k < 3; k++) mdl[d][k] = '{v: 1'b0, w: 1'b0, ld: 1'b0, rn: 0};
                mcnt[d] = 0;
            end else begin
                if (cnt_v[d] && mcnt[d] < cnt_max(d)) mcnt[d]++;
                if (!ph_v[d]) begin
                    mdl[d][2] = mdl[d][1];
                    mdl[d][1] = eb_v[d] ? '{v: 1'b0, w: 1'b0, ld: 1'b0, rn: 0} : mdl[d][0];
                    mdl[d][0] = '{v: id_valid && !ib_v[d], w: id_wreg, ld: id_m2reg, rn: int'(id_rn)};
                end
            end
        end
        @(negedge Clock);
    endtask

    initial begin
        int c0;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) mdl[d][k] = '{v: 1'b0, w: 1'b0, ld: 1'b0, rn: 0};
            mcnt[d] = 0;
        end
        Resetn = 1'b0;
        idle();
        @(negedge Clock);
        tick();
        tick();
        Resetn = 1'b1;

        // reset state
        idle();
        chk("rst_f_pc_we", 32'(f_pc_we), 32'd1);
        chk("rst_n_ir_we", 32'(n_ir_we), 32'd1);
        chk("rst_f_cnt", 32'(f_cnt), 32'd0);
        tick();

        // load-use with forwarding: one stall, then load data forwarded from MEM
        drive(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("lu_pc_we", 32'(f_pc_we), 32'd0);
        chk("lu_idex", 32'(f_idex), 32'd1);
        tick();
        drive(1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("lu_cnt", 32'(f_cnt), 32'd1);
        chk("lu_fwd_a", 32'(f_fwd_a), 32'd3);
        chk("lu_pc_we2", 32'(f_pc_we), 32'd1);
        tick();

        // EXE and MEM both write r7: EXE wins; r0 never forwarded
        drive(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 7, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 7, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 0, 1'b0, 7, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("exe_wins_fwd_b", 32'(f_fwd_b), 32'd1);
        chk("exe_wins_pc_we", 32'(f_pc_we), 32'd1);
        drive(1'b1, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("r0_fwd_b", 32'(f_fwd_b), 32'd0);
        tick();

        // redirect in MEM-resolving unit together with a load-use stall
        drive(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b1);
        tick();
        c0 = mcnt[0];
        drive(1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        chk("br_flush", 32'(f_ir_flush), 32'd1);
        chk("br_idex", 32'(f_idex), 32'd1);
        chk("br_exmem", 32'(f_exmem), 32'd1);
        chk("br_pc_we", 32'(f_pc_we), 32'd1);
        tick();
        drive(1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("br_mem_squashed", 32'(f_fwd_a), 32'd0);
        chk("br_cnt_same", 32'(f_cnt), 32'(c0));
        tick();

        // memory wait for 4 cycles with a pending redirect
        drive(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 9, 1'b0, 1'b0, 1'b1);
        tick();
        c0 = mcnt[0];
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 9, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
            chk("hold_on", 32'(f_hold), 32'd1);
            chk("hold_noflush", 32'(f_ir_flush), 32'd0);
            chk("hold_pc_we", 32'(f_pc_we), 32'd0);
            chk("hold_frozen_fwd", 32'(f_fwd_a), 32'd1);
            tick();
        end
        drive(1'b1, 9, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        chk("hold_cnt", 32'(f_cnt), 32'(c0 + 4));
        chk("hold_redirect", 32'(f_ir_flush), 32'd1);
        tick();

        // full interlock: ALU r3 then reader -> 3 stall cycles, no forwarding
        repeat (3) begin idle(); tick(); end
        drive(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
            chk("il_pc_we", 32'(n_pc_we), (i < 3) ? 32'd0 : 32'd1);
            chk("il_fwd_a", 32'(n_fwd_a), 32'd0);
            tick();
        end

        // reset in the second cycle of an interlock
        repeat (3) begin idle(); tick(); end
        drive(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        tick();
        Resetn = 1'b0;
        drive(1'b1, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        tick();
        Resetn = 1'b1;
        drive(1'b1, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("rst_il_pc_we", 32'(n_pc_we), 32'd1);
        chk("rst_il_cnt", 32'(n_cnt), 32'd0);
        chk("rst_il_idex", 32'(n_idex), 32'd0);
        tick();

        // randomized traffic over a small register set to force collisions
        for (int i = 0; i < 600; i++) begin
            Resetn = ($urandom_range(99) != 0);
            drive(1'($urandom_range(3) != 0), int'($urandom_range(3)), 1'($urandom),
                  int'($urandom_range(3)), 1'($urandom), 1'($urandom_range(3) != 0),
                  1'($urandom), int'($urandom_range(3)), 1'($urandom_range(7) == 0),
                  1'($urandom_range(3) == 0), 1'($urandom));
            tick();
        end
        Resetn = 1'b1;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
